mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide unit in the execute stage, consuming operands and funct3 from the decode-to-execute pipeline register. It stalls the pipeline through `BusyE` while a multi-cycle operation runs, then presents `ResultE` for one cycle so the held instruction advances with its result. It handles all eight M-extension operations: shift-add for multiplies, restoring division for divides and remainders.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `CLK`  input  1  rising-edge clock, the single clock.
- `RST`  input  1  synchronous, active-high reset.
- `StartE`  input  1  a valid M-extension instruction is in E; held high while stalled.
- `FunctE`  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcAE`  input  32  rs1 operand, post-forwarding.
- `SrcBE`  input  32  rs2 operand, post-forwarding.
- `FlushE`  input  1  kill the instruction in E; abort any operation.
- `BusyE`  output  1  stall request to fetch, decode and E registers; combinational.
- `DoneE`  output  1  `ResultE` valid this cycle; registered.
- `ResultE`  output  32  operation result; registered.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `StartE`=1, `FlushE`=0:
  - Latch `FunctE` and operand magnitudes, using two's-complement abs on operands signed for this op.
  - Record result sign:
    - MUL/MULH: sign(A) xor sign(B).
    - MULHSU: sign(A).
    - DIV: sign(A) xor sign(B).
    - REM: sign(A).
    - Unsigned ops: 0.
  - Clear the 6-bit iteration counter, then go to CALC.
- IDLE special cases go straight to DONE with no CALC:
  - Divide by zero (B=0, ops 1xx): quotient 0xFFFFFFFF; remainder = A unchanged.
  - Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): quotient 0x80000000; remainder 0.
- CALC multiply: 64-bit accumulator, one multiplier bit per cycle (shift-add), 32 iterations.
- CALC divide: restoring division, one quotient bit per cycle, 32 iterations, with a 33-bit partial remainder.
- After iteration 32, apply the sign fix:
  - Multiplies: negate the 64-bit product.
  - Divides: negate the quotient or remainder.
- CALC → DONE, registering `ResultE`:
  - MUL: low 32 bits.
  - MULH, MULHSU, MULHU: high 32 bits.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- DONE: `DoneE`=1 for exactly one cycle, then unconditional → IDLE.
  - `StartE` still high in DONE (same instruction) does not restart.
- `BusyE` = (state==CALC) | (state==IDLE & `StartE` & ~`FlushE`).
  - It is low in DONE, so the pipeline advances exactly once with the result.
- `FlushE` in any state: next state IDLE, `DoneE` 0; the partial result is discarded.
  - `FlushE` has priority over `StartE`.
- `RST`: state IDLE, `DoneE` 0, `ResultE` 0, counter 0, internal registers 0.
  - Reset mid-CALC aborts with no `DoneE`.
- `ResultE` holds its last value outside DONE.
  - Consumers qualify it with `DoneE`.

## Timing
- t0 is the cycle `StartE` is seen in IDLE.
- Normal operation:
  - CALC runs t1–t32.
  - DONE is at t33: `DoneE`=1 and `ResultE` valid.
  - `BusyE` is high t0–t32 (33 cycles) and low at t33.
- Special cases (div-by-zero, overflow): DONE at t1; `BusyE` high only at t0.
- Back-to-back M ops:
  - The second instruction enters E at t34.
  - The unit is in IDLE at t34 and starts immediately.
  - Throughput is one op per 34 cycles.
- Operands are sampled only at t0. Changes to `SrcAE`/`SrcBE`/`FunctE` afterwards are ignored.
- There is no combinational path from `SrcAE`/`SrcBE` to any output.

## Test plan
- MUL A=7, B=0xFFFFFFFD (−3) → `BusyE` high t0–t32; `DoneE` at t33 with `ResultE`=0xFFFFFFEB.
- MULH A=B=0x80000000 → `ResultE`=0x40000000; same operands with MULHU → 0x40000000; MULHSU → 0xC0000000.
- DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU A=100, B=7 → 14; REMU → 2.
- DIV A=5, B=0 → `DoneE` at t1, `ResultE`=0xFFFFFFFF; REM → 5; DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM → 0.
- Start a MUL, assert `FlushE` at t10 → `BusyE` low from t11, state IDLE, no `DoneE`; a new DIVU started at t12 completes correctly at t45.
- Start a DIV, assert `RST` at t5 → `ResultE`=0, `DoneE`=0, IDLE; two back-to-back MULs afterwards produce `DoneE` 34 cycles apart with correct results.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mul_div_unit : iterative RV32M multiply/divide unit for the execute stage
// Revision     : 1.0
// ----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            StartE,
  input  logic [2:0]      FunctE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_next;
  logic [2:0]        func_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN:0]   acc_q;
  logic [5:0]        cnt_q;

  logic              a_signed, b_signed, a_neg, b_neg, res_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              last_iter;

  // Operand decode, only meaningful in IDLE when StartE is seen
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (FunctE)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                         a_signed = 1'b1;
      default:                        ;
    endcase
  end

  assign a_neg = a_signed & SrcAE[XLEN-1];
  assign b_neg = b_signed & SrcBE[XLEN-1];
  assign a_mag = a_neg ? -SrcAE : SrcAE;
  assign b_mag = b_neg ? -SrcBE : SrcBE;

  always_comb begin
    res_neg = 1'b0;
    case (FunctE)
      3'b000, 3'b001, 3'b100: res_neg = a_neg ^ b_neg;
      3'b010, 3'b110:         res_neg = a_neg;
      default:                res_neg = 1'b0;
    endcase
  end

  assign div_zero    = FunctE[2] & (SrcBE == '0);
  assign div_ovf     = FunctE[2] & ~FunctE[0] & (SrcAE == {1'b1, {(XLEN-1){1'b0}}})
                       & (SrcBE == '1);
  assign special     = div_zero | div_ovf;
  assign special_res = div_zero ? (FunctE[1] ? SrcAE : '1)
                                : (FunctE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  assign last_iter   = (cnt_q == 6'd31);

  // One iteration of shift-add (acc = {hi, multiplier}) or restoring divide
  // (acc = {partial remainder, dividend/quotient}) sharing one register.
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_trial;
  logic [2*XLEN:0]   acc_next;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quot, rem, calc_res;

  always_comb begin
    mul_sum   = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
    if (func_q[2])
      acc_next = div_trial[XLEN+1] ? {acc_q[2*XLEN-1:0], 1'b0}
                                   : {div_trial[XLEN:0], acc_q[XLEN-2:0], 1'b1};
    else
      acc_next = {1'b0, mul_sum, acc_q[XLEN-1:1]};
    product  = neg_q ? -acc_next[2*XLEN-1:0] : acc_next[2*XLEN-1:0];
    quot     = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem      = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    case (func_q)
      3'b000:                 calc_res = product[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_res = product[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calc_res = quot;
      default:                calc_res = rem;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    BusyE      = 1'b0;
    case (state)
      IDLE: if (StartE && !FlushE) begin
        BusyE      = 1'b1;
        state_next = special ? DONE : CALC;
      end
      CALC: begin
        BusyE = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (FlushE) state_next = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      func_q  <= '0;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      DoneE   <= 1'b0;
      ResultE <= '0;
    end else begin
      DoneE <= (state_next == DONE);
      case (state)
        IDLE: if (StartE && !FlushE) begin
          func_q <= FunctE;
          neg_q  <= res_neg;
          opnd_q <= FunctE[2] ? b_mag : a_mag;
          acc_q  <= {{(XLEN+1){1'b0}}, (FunctE[2] ? a_mag : b_mag)};
          cnt_q  <= '0;
          if (special) ResultE <= special_res;
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 6'd1;
          if (last_iter && !FlushE) ResultE <= calc_res;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// Testbench for mul_div_unit: directed vector table plus flush, reset and
// back-to-back sequences.
module tb_mul_div_unit;

  logic        CLK = 1'b0;
  logic        RST, StartE, FlushE;
  logic [2:0]  FunctE;
  logic [31:0] SrcAE, SrcBE;
  logic        BusyE, DoneE;
  logic [31:0] ResultE;

  int n_tests = 0;
  int n_fail  = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .StartE(StartE), .FunctE(FunctE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .BusyE(BusyE), .DoneE(DoneE), .ResultE(ResultE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, hold StartE until DONE, check latency, busy window and result.
  task automatic run_op(input int idx, input vec_t v);
    int    cyc;
    int    busy_cnt;
    logic  seen;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge CLK);
    FunctE = v.f; SrcAE = v.a; SrcBE = v.b; StartE = 1'b1;
    #1;
    busy_cnt = BusyE ? 1 : 0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (cyc == 1) begin
        SrcAE = $urandom; SrcBE = $urandom; FunctE = 3'($urandom);
      end
      if (DoneE) seen = 1'b1;
      else if (BusyE) busy_cnt++;
    end
    check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    check({tag, "_latency"}, cyc, v.lat);
    check({tag, "_busy_cycles"}, busy_cnt, v.lat);
    check({tag, "_busy_low_in_done"}, {31'b0, BusyE}, 32'd0);
    check({tag, "_result"}, ResultE, v.exp);
    @(negedge CLK);
    StartE = 1'b0;
    @(posedge CLK);
    #1;
    check({tag, "_done_one_cycle"}, {31'b0, DoneE}, 32'd0);
    check({tag, "_result_hold"}, ResultE, v.exp);
  endtask

  initial begin
    int   c;
    int   first_c;
    logic seen_done;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[3]  = '{3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 33};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[14] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        33};
    vecs[15] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        33};
    vecs[16] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
    vecs[17] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[18] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};

    RST = 1'b1; StartE = 1'b0; FlushE = 1'b0;
    FunctE = 3'b0; SrcAE = '0; SrcBE = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("reset_result", ResultE, 32'd0);
    check("reset_done", {31'b0, DoneE}, 32'd0);
    check("reset_busy", {31'b0, BusyE}, 32'd0);

    for (int i = 0; i < 19; i++) run_op(i, vecs[i]);

    // Flush a MUL in flight at t10
    @(negedge CLK);
    FunctE = 3'b000; SrcAE = 32'd7; SrcBE = 32'd3; StartE = 1'b1;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    FlushE = 1'b1; StartE = 1'b0;
    @(posedge CLK);
    #1;
    FlushE = 1'b0;
    check("flush_busy_low", {31'b0, BusyE}, 32'd0);
    check("flush_no_done", {31'b0, DoneE}, 32'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 36; k++) begin
      @(posedge CLK);
      #1;
      if (DoneE) seen_done = 1'b1;
    end
    check("flush_no_late_done", {31'b0, seen_done}, 32'd0);
    run_op(100, '{3'b101, 32'd1000, 32'd10, 32'd100, 33});

    // Reset at t5 of a DIV
    @(negedge CLK);
    FunctE = 3'b100; SrcAE = 32'hFFFFFF9C; SrcBE = 32'd3; StartE = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1; StartE = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_mid_result", ResultE, 32'd0);
    check("rst_mid_done", {31'b0, DoneE}, 32'd0);
    check("rst_mid_busy", {31'b0, BusyE}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Two back-to-back MULs with StartE held high throughout
    @(negedge CLK);
    FunctE = 3'b000; SrcAE = 32'd6; SrcBE = 32'd7; StartE = 1'b1;
    c = 0; first_c = -1; seen_done = 1'b0;
    while (!seen_done && c < 100) begin
      @(posedge CLK);
      #1;
      c++;
      if (DoneE) begin
        if (first_c < 0) begin
          first_c = c;
          check("b2b_first_latency", c, 33);
          check("b2b_first_result", ResultE, 32'd42);
          @(negedge CLK);
          SrcAE = 32'd123; SrcBE = 32'd1000;
        end else begin
          seen_done = 1'b1;
          check("b2b_gap", c - first_c, 34);
          check("b2b_second_result", ResultE, 32'd123000);
        end
      end
    end
    check("b2b_second_seen", {31'b0, seen_done}, 32'd1);
    @(negedge CLK);
    StartE = 1'b0;
    repeat (2) @(posedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
